// File: rtl/mux_pkg.sv
// Shared constants and helpers for the scanning N-to-1 mux.
// Mode encodings and a minimum-one clog2 helper.
package mux_pkg;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_AUTO   = 1'b1;

  function automatic int clog2_min1(input int v);
    int r;
    r = 1;
    while ((1 << r) < v) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/mux_nto1_scan_scan_counter.sv
// Dwell counter plus modulo-N_CH channel index.
// Supports load from a manual select and flags the N_CH-1 -> 0 step.
module scan_counter
  import mux_pkg::*;
#(
  parameter int  N_CH  = 8,
  parameter int  DWELL = 4,
  localparam int SEL_W = clog2_min1(N_CH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             load,
  input  logic             load_ok,
  input  logic [SEL_W-1:0] load_idx,
  output logic [SEL_W-1:0] idx,
  output logic             wrap_nxt
);

  localparam int CW = clog2_min1(DWELL + 1);
  localparam logic [CW-1:0]    CNT_END = CW'(DWELL - 1);
  localparam logic [SEL_W-1:0] IDX_END = SEL_W'(N_CH - 1);

  logic [CW-1:0] cnt;
  logic          step;

  assign step     = (cnt == CNT_END);
  assign wrap_nxt = run && step && (idx == IDX_END);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
    end else if (load) begin
      cnt <= '0;
      if (load_ok) idx <= load_idx;
    end else if (run) begin
      if (step) begin
        cnt <= '0;
        idx <= (idx == IDX_END) ? '0 : idx + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_nto1_scan.sv
// Registered N-to-1 mux with manual select or timed auto-scan.
// Priority: reset, then enable, then mode.
module mux_nto1_scan
  import mux_pkg::*;
#(
  parameter int  N_CH  = 8,
  parameter int  W     = 1,
  parameter int  DWELL = 4,
  localparam int SEL_W = clog2_min1(N_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              En,
  input  logic              mode,
  input  logic [SEL_W-1:0]  s,
  input  logic [N_CH*W-1:0] A,
  output logic [W-1:0]      y,
  output logic              y_valid,
  output logic [SEL_W-1:0]  sel,
  output logic              wrap
);

  localparam logic [SEL_W:0] NCH = (SEL_W + 1)'(N_CH);

  logic             s_ok;
  logic             run;
  logic             load;
  logic [SEL_W-1:0] idx;
  logic             wrap_nxt;

  assign s_ok = ({1'b0, s} < NCH);
  assign run  = En && (mode == MODE_AUTO);
  assign load = En && (mode == MODE_MANUAL);

  scan_counter #(
    .N_CH  (N_CH),
    .DWELL (DWELL)
  ) u_scan (
    .clk      (clk),
    .rst_n    (rst_n),
    .run      (run),
    .load     (load),
    .load_ok  (s_ok),
    .load_idx (s),
    .idx      (idx),
    .wrap_nxt (wrap_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y       <= '0;
      y_valid <= 1'b0;
      sel     <= '0;
      wrap    <= 1'b0;
    end else if (!En) begin
      y       <= '0;
      y_valid <= 1'b0;
      wrap    <= 1'b0;
    end else if (mode == MODE_MANUAL) begin
      wrap <= 1'b0;
      if (s_ok) begin
        y       <= A[int'(s)*W +: W];
        y_valid <= 1'b1;
        sel     <= s;
      end else begin
        y       <= '0;
        y_valid <= 1'b0;
      end
    end else begin
      // Output shows the index before this edge's advance.
      y       <= A[int'(idx)*W +: W];
      y_valid <= 1'b1;
      sel     <= idx;
      wrap    <= wrap_nxt;
    end
  end

endmodule

// File: doc/mux_nto1_scan.md
Name: mux_nto1_scan

Overview:
Parametrised, registered N-to-1 multiplexer with enable; successor to the 8-to-1 combinational mux.
Adds a registered output, valid flag and two modes:
- Manual: select taken from input `s`.
- Auto-scan: select generated internally, stepping through channels every DWELL cycles.

Used to time-multiplex channel data onto a single output (LED scan, serial sampling).

Parameters:
- N_CH, 8, number of input channels (2..256; need not be a power of two).
- W, 1, bit width of each channel.
- SEL_W, $clog2(N_CH), select width (derived; not overridden).
- DWELL, 4, cycles per channel in auto-scan mode (1..65535).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- En  in  1  enable; 0 forces output low and freezes scan state.
- mode  in  1  0 = manual (use s), 1 = auto-scan.
- s  in  SEL_W  manual channel select.
- A  in  N_CH*W  packed channel data; channel k = A[k*W +: W].
- y  out  W  registered selected channel data.
- y_valid  out  1  y holds data of a legal channel.
- sel  out  SEL_W  channel index that y currently reflects.
- wrap  out  1  one-cycle pulse when auto-scan returns from N_CH-1 to 0.

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset (rst_n=0, async): y=0, y_valid=0, sel=0, wrap=0, dwell counter=0, scan index=0. Release is synchronous to the next clk edge.
- Latency: one cycle. y/sel/y_valid at edge t+1 reflect A, s, En and mode sampled at edge t.
- En=0 at an edge:
  - y<=0, y_valid<=0, wrap<=0.
  - sel, scan index and dwell counter hold their values.
- Manual mode (En=1, mode=0):
  - s < N_CH: sel<=s, y<=A[s], y_valid<=1.
  - s >= N_CH (only possible when N_CH is not a power of two): y<=0, y_valid<=0, sel holds.
  - Scan index is loaded with s (if legal) and the dwell counter is cleared, so a later switch to auto starts from the last manual channel.
- Auto-scan mode (En=1, mode=1):
  - Dwell counter counts 0..DWELL-1.
  - At DWELL-1: counter wraps to 0 and scan index advances (N_CH-1 -> 0, never passing through illegal codes).
  - Each cycle: y<=A[scan index] (the index value before the advance), sel<=that index, y_valid<=1.
  - wrap<=1 exactly on the cycle the index advances from N_CH-1 to 0; otherwise 0.
- DWELL=1: index advances every enabled cycle.
- Mode change auto->manual: takes effect at the next edge; counter state is discarded.
- A changing mid-dwell: y tracks the new A of the current channel with one-cycle latency (no capture/hold).
- Input s is ignored in auto mode.
- rst_n asserted mid-scan: immediate clear per the reset values above; scan restarts at channel 0.

State:
- Scan index register (SEL_W bits).
- Dwell counter ($clog2(DWELL+1) bits).
- Output registers.
- No explicit FSM beyond the mode/enable priority: reset > En=0 > mode.

Decomposition:
- Shared package mux_pkg:
  - Mode constants MODE_MANUAL=1'b0 and MODE_AUTO=1'b1.
  - Function clog2_min1 (returns >=1).
- One natural sub-module, scan_counter: dwell counter plus modulo-N_CH index with load, enable and wrap pulse.
- The mux slice itself stays inline (indexed part-select).

Test Plan:
1. Defaults, A=8'b01011010, En=0, mode=0, s=0..7 -> y=0, y_valid=0 for all cycles; sel stays 0.
2. En=1, mode=0, s stepped 0..7 holding each 3 cycles -> one cycle after each change y = 0,1,0,1,1,0,1,0; y_valid=1; sel=s.
3. En=1, mode=1, DWELL=4, from reset -> y sequence 0,0,0,0,1,1,1,1,0,0,0,0,... following A[0..7]; wrap pulses exactly once every 32 cycles, on the sel 7->0 transition.
4. N_CH=5, W=4, A={4'hE,4'hD,4'hC,4'hB,4'hA}, manual s=6 -> y=0, y_valid=0, sel holds the previous value; then auto with DWELL=1 -> y cycles A,B,C,D,E,A with wrap after E.
5. Auto scan at sel=3, then pulse En=0 for 5 cycles -> y=0 and y_valid=0 during the pulse; on resume sel continues at 3 with the remaining dwell count unchanged.
6. Auto scan mid-dwell, assert rst_n=0 between clock edges -> y, y_valid, sel and wrap clear immediately without a clock; after release, scan restarts at channel 0 with a full DWELL count.
